cbus_arbiter: RTL and testbench

CBUS_ARBITER -- requirements
Module: cbus_arbiter

---
 rtl/cbus_arbiter.sv | 122 ++++++++++++
 tb/tb_cbus_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ upstream CBus requesters onto one
// downstream slave, holding ownership from grant until the slave signals last.
module cbus_arbiter #(
    parameter int NUM_REQ = 2,
    // Request layout, MSB..LSB: valid, is_write, size[2:0], addr[63:0],
    // strobe[7:0], data[63:0], len[7:0], burst[1:0].
    localparam int REQ_W  = 151,
    // Response layout, MSB..LSB: ready, last, data[63:0].
    localparam int RESP_W = 66,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ*REQ_W-1:0]  ireqs,
    output logic [NUM_REQ*RESP_W-1:0] iresps,
    output logic [REQ_W-1:0]          oreq,
    input  logic [RESP_W-1:0]         oresp
);

    localparam int VALID_BIT = REQ_W - 1;
    localparam int LEN_LSB   = 2;
    localparam int READY_BIT = RESP_W - 1;
    localparam int LAST_BIT  = RESP_W - 2;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [15:0]       busyCycles_q, busyCycles_d;

    logic              grantValid;
    logic [PTR_W-1:0]  grantIdx;
    logic [PTR_W-1:0]  ownerNext;
    logic              done;

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grantValid && ireqs[((int'(ptr_q) + k) % NUM_REQ) * REQ_W + VALID_BIT]) begin
                grantValid = 1'b1;
                grantIdx   = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign ownerNext = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign done      = (state_q == BUSY) && oresp[READY_BIT] && oresp[LAST_BIT];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        busyCycles_d = busyCycles_q;
        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    state_d      = BUSY;
                    owner_d      = grantIdx;
                    busyCycles_d = '0;
                end
            end
            BUSY: begin
                if (busyCycles_q != 16'hFFFF) begin
                    busyCycles_d = busyCycles_q + 16'd1;
                end
                if (done) begin
                    state_d = IDLE;
                    ptr_d   = ownerNext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            busyCycles_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            busyCycles_q <= busyCycles_d;
        end
    end

    // Request and response paths are kept in separate blocks so the slave may
    // answer combinationally without forming an apparent loop.
    always_comb begin
        oreq = '0;
        if (state_q == BUSY) begin
            oreq = ireqs[int'(owner_q) * REQ_W +: REQ_W];
        end
    end

    always_comb begin
        iresps = '0;
        if (state_q == BUSY) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (owner_q == PTR_W'(j)) begin
                    iresps[j * RESP_W +: RESP_W] = oresp;
                end
            end
        end
    end

    // A hung slave shows up as a transaction far longer than its burst length.
    always_ff @(posedge clk) begin
        if (!reset && state_q == BUSY) begin
            assert (busyCycles_q <= 16'd256 + {8'd0, oreq[LEN_LSB +: 8]});
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: a combinational slave model answers the granted
// request, expected beats go into a scoreboard queue, and a monitor checks them.
module tb_cbus_arbiter;

    localparam int REQ_W  = 151;
    localparam int RESP_W = 66;
    localparam logic [1:0] FIXED = 2'd0;
    localparam logic [1:0] INCR  = 2'd1;
    localparam logic [2:0] MSIZE8 = 3'd3;

    typedef struct packed {
        logic [1:0]  idx;
        logic [63:0] data;
        logic        last;
    } expEntry_t;

    logic                  clk;
    logic                  reset;
    logic [2*REQ_W-1:0]    ireqs;
    logic [2*RESP_W-1:0]   iresps;
    logic [REQ_W-1:0]      oreq;
    logic [RESP_W-1:0]     oresp;

    logic [REQ_W-1:0]      reqArr [2];
    logic [63:0]           slaveBase;
    logic [7:0]            beat;
    expEntry_t             expQ [$];
    expEntry_t             monE;
    int                    total = 0;
    int                    bad = 0;

    cbus_arbiter #(.NUM_REQ(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign ireqs = {reqArr[1], reqArr[0]};

    // Slave model: ready on every cycle the forwarded request is valid,
    // data counts up from slaveBase, last on beat number len.
    always_comb begin
        oresp = '0;
        if (oreq[REQ_W-1]) begin
            oresp[65]   = 1'b1;
            oresp[64]   = (beat == oreq[9:2]);
            oresp[63:0] = slaveBase + {56'd0, beat};
        end
    end

    always @(posedge clk) begin
        if (reset) beat <= 8'd0;
        else if (oresp[65] && oresp[64]) beat <= 8'd0;
        else if (oresp[65]) beat <= beat + 8'd1;
    end

    // Monitor: every ready beat on any upstream port must match the queue head.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (iresps[i*RESP_W + 65]) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpectedBeat: got beat on port %0d data %0h, expected none", i, iresps[i*RESP_W +: 64]);
                end else begin
                    monE = expQ.pop_front();
                    if (int'(monE.idx) != i || monE.data !== iresps[i*RESP_W +: 64] || monE.last !== iresps[i*RESP_W + 64]) begin
                        bad++;
                        $display("[TB] FAIL respBeat: got port=%0d data=%0h last=%0b, expected port=%0d data=%0h last=%0b",
                                 i, iresps[i*RESP_W +: 64], iresps[i*RESP_W + 64], monE.idx, monE.data, monE.last);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [REQ_W-1:0] mkReq(input logic v, input logic [2:0] size, input logic [63:0] addr,
                                               input logic [7:0] len, input logic [1:0] burst);
        return {v, 1'b0, size, addr, 8'hFF, ~addr, len, burst};
    endfunction

    task automatic applyStimulus(input int idx, input logic [REQ_W-1:0] req);
        reqArr[idx] = req;
    endtask

    task automatic pushExp(input logic [1:0] idx, input logic [63:0] data, input logic last);
        expEntry_t e;
        e.idx  = idx;
        e.data = data;
        e.last = last;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Waits for last on port idx, steps past the completion edge, optionally
    // withdraws the request, and confirms the mandatory IDLE gap.
    task automatic waitLast(input int idx, input bit dropAfter);
        bit seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (iresps[idx*RESP_W + 65] && iresps[idx*RESP_W + 64]) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL lastTimeout: got no last on port %0d, expected last within 20 cycles", idx);
        end
        @(posedge clk);
        #1;
        if (dropAfter) reqArr[idx][REQ_W-1] = 1'b0;
        checkOutput("gapIdleOreq", 256'(oreq), 256'd0);
    endtask

    initial begin
        reset     = 1'b1;
        reqArr[0] = '0;
        reqArr[1] = '0;
        slaveBase = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstOreq", 256'(oreq), 256'd0);
        checkOutput("rstIresps", 256'(iresps), 256'd0);
        checkOutput("rstPtr", 256'(dut.ptr_q), 256'd0);
        reset = 1'b0;

        // Single requester, single beat.
        slaveBase = 64'h1122334455667788;
        pushExp(2'd0, 64'h1122334455667788, 1'b1);
        applyStimulus(0, mkReq(1'b1, MSIZE8, 64'h80000000, 8'd0, FIXED));
        @(negedge clk);
        checkOutput("idleOreq", 256'(oreq), 256'd0);
        @(negedge clk);
        checkOutput("busyOreq", 256'(oreq), 256'(reqArr[0]));
        checkOutput("busyData0", 256'(iresps[63:0]), 256'(64'h1122334455667788));
        @(posedge clk);
        #1;
        applyStimulus(0, '0);
        checkOutput("doneOreq", 256'(oreq), 256'd0);
        checkOutput("donePtr", 256'(dut.ptr_q), 256'd1);

        // Contention from reset release: ptr must restart at 0, then alternate.
        reset     = 1'b1;
        slaveBase = 64'hC0FFEE0000000000;
        applyStimulus(0, mkReq(1'b1, MSIZE8, 64'h1000, 8'd0, FIXED));
        applyStimulus(1, mkReq(1'b1, MSIZE8, 64'h2000, 8'd0, FIXED));
        @(posedge clk);
        #1;
        checkOutput("rstPtrAgain", 256'(dut.ptr_q), 256'd0);
        reset = 1'b0;
        pushExp(2'd0, 64'hC0FFEE0000000000, 1'b1);
        pushExp(2'd1, 64'hC0FFEE0000000000, 1'b1);
        pushExp(2'd0, 64'hC0FFEE0000000000, 1'b1);
        pushExp(2'd1, 64'hC0FFEE0000000000, 1'b1);
        waitLast(0, 1'b0);
        waitLast(1, 1'b0);
        waitLast(0, 1'b1);
        waitLast(1, 1'b1);

        // INCR burst on req1 while req0 waits.
        slaveBase = 64'hA000000000000000;
        pushExp(2'd1, 64'hA000000000000000, 1'b0);
        pushExp(2'd1, 64'hA000000000000001, 1'b0);
        pushExp(2'd1, 64'hA000000000000002, 1'b0);
        pushExp(2'd1, 64'hA000000000000003, 1'b1);
        pushExp(2'd0, 64'hA000000000000000, 1'b1);
        applyStimulus(1, mkReq(1'b1, MSIZE8, 64'h3000, 8'd3, INCR));
        @(posedge clk);
        #1;
        applyStimulus(0, mkReq(1'b1, MSIZE8, 64'h3800, 8'd0, FIXED));
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            checkOutput("burstIresp0Zero", 256'(iresps[65:0]), 256'd0);
            checkOutput("burstOreq", 256'(oreq), 256'(reqArr[1]));
        end
        @(posedge clk);
        #1;
        applyStimulus(1, '0);
        checkOutput("burstGapOreq", 256'(oreq), 256'd0);
        waitLast(0, 1'b1);

        // Owner drops valid mid-burst; grant must be held until last.
        slaveBase = 64'hB000000000000000;
        pushExp(2'd1, 64'hB000000000000000, 1'b0);
        pushExp(2'd1, 64'hB000000000000001, 1'b0);
        pushExp(2'd1, 64'hB000000000000002, 1'b0);
        pushExp(2'd1, 64'hB000000000000003, 1'b1);
        pushExp(2'd0, 64'hB000000000000000, 1'b1);
        applyStimulus(1, mkReq(1'b1, MSIZE8, 64'h4000, 8'd3, INCR));
        @(posedge clk);
        #1;
        applyStimulus(0, mkReq(1'b1, MSIZE8, 64'h4800, 8'd0, FIXED));
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        applyStimulus(1, mkReq(1'b0, MSIZE8, 64'h4000, 8'd3, INCR));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("dropOreqHeld", 256'(oreq), 256'(reqArr[1]));
            checkOutput("dropIresp0Zero", 256'(iresps[65:0]), 256'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(1, mkReq(1'b1, MSIZE8, 64'h4000, 8'd3, INCR));
        waitLast(1, 1'b1);
        waitLast(0, 1'b1);

        // Reset pulsed on the third beat of a len=7 burst.
        slaveBase = 64'hD000000000000000;
        pushExp(2'd0, 64'hD000000000000000, 1'b0);
        pushExp(2'd0, 64'hD000000000000001, 1'b0);
        pushExp(2'd0, 64'hD000000000000002, 1'b0);
        applyStimulus(0, mkReq(1'b1, MSIZE8, 64'h5000, 8'd7, INCR));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstOreq", 256'(oreq), 256'd0);
        checkOutput("midRstIresps", 256'(iresps), 256'd0);
        checkOutput("midRstPtr", 256'(dut.ptr_q), 256'd0);
        reset = 1'b0;
        applyStimulus(0, '0);
        applyStimulus(1, mkReq(1'b1, MSIZE8, 64'h6000, 8'd0, FIXED));
        pushExp(2'd1, 64'hD000000000000000, 1'b1);
        @(negedge clk);
        checkOutput("postRstIdle", 256'(oreq), 256'd0);
        @(negedge clk);
        checkOutput("postRstGrant", 256'(oreq), 256'(reqArr[1]));
        @(posedge clk);
        #1;
        applyStimulus(1, '0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", 256'(expQ.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
